// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode and FSM state definitions shared by the ULA sequencer
// Contents: OP_ADD..OP_MUL opcode localparams, state_t FSM encoding.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_GT  = 3'b010;
  localparam logic [2:0] OP_LT  = 3'b011;
  localparam logic [2:0] OP_GE  = 3'b100;
  localparam logic [2:0] OP_LE  = 3'b101;
  localparam logic [2:0] OP_EQ  = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/ula_mul_seq.sv
// rtl/ula_mul_seq.sv - N-iteration shift-add multiplier with start/busy/done
// Ports:
//   clk, rst (sync active-high), en (0 freezes all state)
//   start   : latch a/b and begin; ignored unless en
//   a, b    : N-bit operands (two's complement when SIGNED=1)
//   busy    : iterations in progress
//   done    : final iteration happens on this edge; product is valid now
//   product : 2N-bit result of the final iteration (combinational)
module ula_mul_seq #(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc_nxt;
  logic [N-1:0]   mplier;
  logic           neg;
  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  // Magnitudes are N-bit unsigned, so the most negative value maps to 2^(N-1)
  // without overflow.
  always_comb begin
    a_neg   = SIGNED && a[N-1];
    b_neg   = SIGNED && b[N-1];
    a_mag   = a_neg ? (~a + 1'b1) : a;
    b_mag   = b_neg ? (~b + 1'b1) : b;
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    done    = busy && (cnt == CNT_LAST);
    product = neg ? (~acc_nxt + 1'b1) : acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (en) begin
      if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{N{1'b0}}, a_mag};
        mplier <= b_mag;
        neg    <= a_neg ^ b_neg;
      end else if (busy) begin
        acc    <= acc_nxt;
        mcand  <= {mcand[2*N-2:0], 1'b0};
        mplier <= {1'b0, mplier[N-1:1]};
        if (done) begin
          busy <= 1'b0;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - handshaked N-bit ULA with registered results and sequential multiply
// Ports:
//   Tclk, Tclr (sync active-high, priority over en), en (0 stalls everything)
//   A_in, B_in, selec, in_valid / in_ready : request side, sampled on accept
//   S (N+1), Smulti (2N), zero, out_valid / out_ready : result side
module ula_seq
  import ula_pkg::*;
#(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic           Tclk,
  input  logic           Tclr,
  input  logic           en,
  input  logic [N-1:0]   A_in,
  input  logic [N-1:0]   B_in,
  input  logic [2:0]     selec,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N:0]     S,
  output logic [2*N-1:0] Smulti,
  output logic           zero,
  output logic           out_valid,
  input  logic           out_ready
);

  state_t         state;
  logic           accept;
  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic [2*N-1:0] mul_product;
  logic [N:0]     alu_s;
  logic           gt;
  logic           lt;
  logic           eq;

  assign in_ready  = (state == ST_IDLE) && !mul_busy && en && !Tclr;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (selec == OP_MUL);

  // Single-cycle ops are computed straight from the inputs so the result
  // lands in the output registers on the accepting edge.
  always_comb begin
    if (SIGNED) begin
      gt = $signed(A_in) > $signed(B_in);
      lt = $signed(A_in) < $signed(B_in);
    end else begin
      gt = A_in > B_in;
      lt = A_in < B_in;
    end
    eq = (A_in == B_in);
    case (selec)
      OP_ADD:  alu_s = {1'b0, A_in} + {1'b0, B_in};
      OP_SUB:  alu_s = {1'b0, A_in} - {1'b0, B_in};
      OP_GT:   alu_s = {{N{1'b0}}, gt};
      OP_LT:   alu_s = {{N{1'b0}}, lt};
      OP_GE:   alu_s = {{N{1'b0}}, !lt};
      OP_LE:   alu_s = {{N{1'b0}}, !gt};
      OP_EQ:   alu_s = {{N{1'b0}}, eq};
      default: alu_s = '0;
    endcase
  end

  ula_mul_seq #(
    .N      (N),
    .SIGNED (SIGNED)
  ) u_mul (
    .clk     (Tclk),
    .rst     (Tclr),
    .en      (en),
    .start   (mul_start),
    .a       (A_in),
    .b       (B_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge Tclk) begin
    if (Tclr) begin
      state     <= ST_IDLE;
      S         <= '0;
      Smulti    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (selec == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              S         <= alu_s;
              Smulti    <= '0;
              zero      <= (alu_s == '0);
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            S         <= '0;
            Smulti    <= mul_product;
            zero      <= (mul_product == '0);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Outputs keep their values after the handshake; only out_valid drops.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - directed table-driven bench for ula_seq (N=8, unsigned and signed)
module tb_ula_seq;
  import ula_pkg::*;

  logic        Tclk = 1'b0;
  logic        Tclr;
  logic        en;
  logic [7:0]  A_in;
  logic [7:0]  B_in;
  logic [2:0]  selec;
  logic        in_valid;
  logic        out_ready;

  logic        ir_u, ir_s, ov_u, ov_s, z_u, z_s;
  logic [8:0]  s_u, s_s;
  logic [15:0] m_u, m_s;

  logic        sg;
  logic        cur_ir, cur_ov, cur_z;
  logic [8:0]  cur_s;
  logic [15:0] cur_m;

  int passed = 0;
  int total  = 0;

  ula_seq #(.N(8), .SIGNED(1'b0)) dut_u (
    .Tclk(Tclk), .Tclr(Tclr), .en(en), .A_in(A_in), .B_in(B_in), .selec(selec),
    .in_valid(in_valid), .in_ready(ir_u), .S(s_u), .Smulti(m_u), .zero(z_u),
    .out_valid(ov_u), .out_ready(out_ready)
  );

  ula_seq #(.N(8), .SIGNED(1'b1)) dut_s (
    .Tclk(Tclk), .Tclr(Tclr), .en(en), .A_in(A_in), .B_in(B_in), .selec(selec),
    .in_valid(in_valid), .in_ready(ir_s), .S(s_s), .Smulti(m_s), .zero(z_s),
    .out_valid(ov_s), .out_ready(out_ready)
  );

  always #5 Tclk = ~Tclk;

  always_comb begin
    cur_ir = sg ? ir_s : ir_u;
    cur_ov = sg ? ov_s : ov_u;
    cur_z  = sg ? z_s  : z_u;
    cur_s  = sg ? s_s  : s_u;
    cur_m  = sg ? m_s  : m_u;
  end

  typedef struct {
    bit         sg;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
    logic       z;
    logic [15:0] m;
    int         lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Tclk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    sg = v.sg; A_in = v.a; B_in = v.b; selec = v.op;
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk({tag, " in_ready"}, 32'(cur_ir), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!cur_ov && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " S"}, 32'(cur_s), 32'(v.s));
    chk({tag, " Smulti"}, 32'(cur_m), 32'(v.m));
    chk({tag, " zero"}, 32'(cur_z), 32'(v.z));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 32'(cur_ov), 32'd0);
    chk({tag, " ready again"}, 32'(cur_ir), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int stale;
    vec_t v;

    vecs[0]  = '{1'b0, OP_GT,  8'd200, 8'd3,   9'd1,   1'b0, 16'h0000, 0};
    vecs[1]  = '{1'b0, OP_LT,  8'd55,  8'd100, 9'd1,   1'b0, 16'h0000, 0};
    vecs[2]  = '{1'b0, OP_EQ,  8'd50,  8'd50,  9'd1,   1'b0, 16'h0000, 0};
    vecs[3]  = '{1'b0, OP_GE,  8'd55,  8'd100, 9'd0,   1'b1, 16'h0000, 0};
    vecs[4]  = '{1'b0, OP_LE,  8'd50,  8'd50,  9'd1,   1'b0, 16'h0000, 0};
    vecs[5]  = '{1'b0, OP_SUB, 8'd3,   8'd200, 9'h13B, 1'b0, 16'h0000, 0};
    vecs[6]  = '{1'b0, OP_ADD, 8'd200, 8'd100, 9'd300, 1'b0, 16'h0000, 0};
    vecs[7]  = '{1'b0, OP_ADD, 8'd0,   8'd0,   9'd0,   1'b1, 16'h0000, 0};
    vecs[8]  = '{1'b0, OP_MUL, 8'd255, 8'd255, 9'd0,   1'b0, 16'hFE01, 8};
    vecs[9]  = '{1'b1, OP_MUL, 8'hFE,  8'h03,  9'd0,   1'b0, 16'hFFFA, 8};
    vecs[10] = '{1'b1, OP_GT,  8'hFE,  8'h03,  9'd0,   1'b1, 16'h0000, 0};
    vecs[11] = '{1'b0, OP_GT,  8'hFE,  8'h03,  9'd1,   1'b0, 16'h0000, 0};
    vecs[12] = '{1'b1, OP_LT,  8'h80,  8'h7F,  9'd1,   1'b0, 16'h0000, 0};
    vecs[13] = '{1'b1, OP_SUB, 8'h00,  8'h01,  9'h1FF, 1'b0, 16'h0000, 0};
    vecs[14] = '{1'b0, OP_MUL, 8'h00,  8'h4D,  9'd0,   1'b1, 16'h0000, 8};
    vecs[15] = '{1'b1, OP_MUL, 8'h80,  8'h80,  9'd0,   1'b0, 16'h4000, 8};
    vecs[16] = '{1'b1, OP_MUL, 8'h7F,  8'h81,  9'd0,   1'b0, 16'hC0FF, 8};
    vecs[17] = '{1'b0, OP_ADD, 8'hFF,  8'hFF,  9'h1FE, 1'b0, 16'h0000, 0};

    sg = 1'b0; Tclr = 1'b1; en = 1'b1; A_in = '0; B_in = '0; selec = OP_ADD;
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset held two cycles.
    tick();
    tick();
    chk("reset S", 32'(s_u), 32'd0);
    chk("reset Smulti", 32'(m_u), 32'd0);
    chk("reset zero", 32'(z_u), 32'd0);
    chk("reset out_valid", 32'(ov_u), 32'd0);
    chk("reset in_ready", 32'(ir_u), 32'd0);
    Tclr = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(ir_u), 32'd1);

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held, new requests ignored while in DONE.
    sg = 1'b0; A_in = 8'd10; B_in = 8'd20; selec = OP_ADD; in_valid = 1'b1;
    tick();
    A_in = 8'd1; B_in = 8'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d out_valid", i), 32'(ov_u), 32'd1);
      chk($sformatf("bp%0d S", i), 32'(s_u), 32'd30);
      chk($sformatf("bp%0d in_ready", i), 32'(ir_u), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release out_valid", 32'(ov_u), 32'd0);
    chk("bp release in_ready", 32'(ir_u), 32'd1);
    chk("bp S kept", 32'(s_u), 32'd30);
    v = '{1'b0, OP_EQ, 8'd5, 8'd5, 9'd1, 1'b0, 16'h0000, 0};
    run_op(v, "bp next");

    // Stall of three cycles in the middle of a multiply.
    sg = 1'b0; A_in = 8'd12; B_in = 8'd13; selec = OP_MUL; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    tick(); lat++;
    tick(); lat++;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); lat++;
      chk($sformatf("stall%0d out_valid", i), 32'(ov_u), 32'd0);
      chk($sformatf("stall%0d in_ready", i), 32'(ir_u), 32'd0);
    end
    en = 1'b1;
    while (!ov_u && lat < 40) begin
      tick();
      lat++;
    end
    chk("stall latency", 32'(lat), 32'd11);
    chk("stall Smulti", 32'(m_u), 32'h009C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a multiply aborts it.
    A_in = 8'd7; B_in = 8'd9; selec = OP_MUL; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    Tclr = 1'b1;
    tick();
    chk("abort out_valid", 32'(ov_u), 32'd0);
    chk("abort in_ready", 32'(ir_u), 32'd0);
    chk("abort Smulti", 32'(m_u), 32'd0);
    chk("abort S", 32'(s_u), 32'd0);
    Tclr = 1'b0;
    #1;
    chk("abort ready after", 32'(ir_u), 32'd1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov_u) stale++;
    end
    chk("abort no stale result", 32'(stale), 32'd0);
    v = '{1'b0, OP_ADD, 8'd1, 8'd2, 9'd3, 1'b0, 16'h0000, 0};
    run_op(v, "abort next");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
